// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single Instruction_Memory read port between the
// CPU fetch port (0, priority, flushable) and a debug/trace reader (1, with
// anti-starvation). In-flight reads are tracked by a MEM_LATENCY-deep tag pipe
// and each returned word is routed back to the port that issued it.
module imem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // port 0: CPU fetch
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              flush0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  // port 1: debug/trace reader
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  // Instruction_Memory read port
  output logic [ADDR_W-1:0] mem_read_address,
  input  logic [DATA_W-1:0] mem_inst
);

  localparam int unsigned      CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

  // One in-flight read: valid bit plus the port that issued it.
  typedef struct packed {
    logic vld;
    logic port;
  } tag_t;

  logic                         win0;
  logic                         win1;
  logic                         issue;
  logic [CNT_W-1:0]             starve_q;
  logic [CNT_W-1:0]             starve_d;
  logic [ADDR_W-1:0]            last_addr_q;
  tag_t [MEM_LATENCY-1:0]       pipe_q;
  tag_t [MEM_LATENCY-1:0]       pipe_d;
  tag_t [MEM_LATENCY-1:0]       kept;
  tag_t                         exit_tag;
  logic                         deliver0;
  logic                         deliver1;

  // Winner select: port 0 first, port 1 when alone or starved; nothing in reset.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (!rst) begin
      if (req1 && (!req0 || (starve_q >= LIMIT))) begin
        win1 = 1'b1;
      end else if (req0) begin
        win0 = 1'b1;
      end
    end
  end

  assign gnt0  = win0;
  assign gnt1  = win1;
  assign issue = win0 | win1;

  // Address to memory: the winner's address, else the last issued one.
  always_comb begin
    mem_read_address = last_addr_q;
    if (win0) begin
      mem_read_address = addr0;
    end else if (win1) begin
      mem_read_address = addr1;
    end
  end

  // Remember the last issued address so the memory input is stable when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_addr_q <= '0;
    end else if (issue) begin
      last_addr_q <= mem_read_address;
    end
  end

  // Starvation count: consecutive cycles port 1 asked and lost, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!req1 || win1) begin
      starve_d = '0;
    end else if (starve_q != CNT_MAX) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Flush drops every port-0 entry already in flight, including the exiting one.
  always_comb begin
    kept = pipe_q;
    for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
      if (flush0 && !pipe_q[i].port) begin
        kept[i].vld = 1'b0;
      end
    end
    exit_tag = kept[MEM_LATENCY-1];
    deliver0 = exit_tag.vld & ~exit_tag.port;
    deliver1 = exit_tag.vld &  exit_tag.port;
  end

  // Next tag pipe: the new grant enters stage 0 unflushed, the rest shift on.
  always_comb begin
    pipe_d         = kept;
    pipe_d[0].vld  = issue;
    pipe_d[0].port = win1;
    for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
      pipe_d[i] = kept[i-1];
    end
  end

  // Tag pipe register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Registered responses; data holds between deliveries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= deliver0;
      rvalid1 <= deliver1;
      if (deliver0) begin
        rdata0 <= mem_inst;
      end
      if (deliver1) begin
        rdata1 <= mem_inst;
      end
    end
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single read port of Instruction_Memory between two requesters: port 0 (CPU fetch) and port 1 (debug/trace reader).
- Issues at most one address per cycle and tracks in-flight reads through a MEM_LATENCY-deep tag pipe.
- Routes each returned instruction word to the requester that issued it.
- Port 0 has priority; port 1 is protected by an anti-starvation counter. Port 0 has a flush input for branch redirects.

Parameters:
- ADDR_W, 32, width of the read address.
- DATA_W, 32, width of the instruction word.
- MEM_LATENCY, 1, cycles from mem_read_address driven to mem_inst valid; legal range 1..4.
- STARVE_LIMIT, 4, consecutive lost cycles after which port 1 wins arbitration; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  port 0 request; addr0 must be held stable while req0=1 and gnt0=0.
- addr0  input  ADDR_W  port 0 read address.
- flush0  input  1  discard all port-0 reads currently in flight.
- gnt0  output  1  port 0 address accepted this cycle.
- rvalid0  output  1  rdata0 is valid this cycle.
- rdata0  output  DATA_W  port 0 instruction word.
- req1, addr1, gnt1, rvalid1, rdata1  same as port 0; port 1 has no flush.
- mem_read_address  output  ADDR_W  address to Instruction_Memory.read_address.
- mem_inst  input  DATA_W  from Instruction_Memory.inst.

Behaviour:
- Reset (async, immediate, asserted or mid-operation):
  - gnt0=gnt1=rvalid0=rvalid1=0; rdata0=rdata1=0; mem_read_address=0.
  - Tag pipe cleared, starvation counter=0.
  - Reads in flight at reset are never delivered.
- Grants:
  - gnt0, gnt1 and the winner select are combinational from req0, req1 and the starvation counter.
  - mem_read_address is combinational from the winning address. When idle it holds the last issued address via a register.
  - At most one of gnt0/gnt1 is high per cycle. A request is accepted on the cycle its gnt is 1.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: port 0 wins, unless the starvation counter is at or above STARVE_LIMIT, in which case port 1 wins.
- Starvation counter:
  - Increments (saturating at 15) on each cycle req1=1 and gnt1=0.
  - Clears on gnt1, and on any cycle with req1=0.
- Tag pipe:
  - MEM_LATENCY stages, each holding {valid, port_id}.
  - Stage 0 loads {gnt0|gnt1, gnt1}; the pipe shifts every cycle. No back-pressure.
- Response:
  - When the last stage is valid, the selected rvalidN=1 and rdataN=mem_inst, registered (one cycle after the stage exits).
  - Latency from gnt to rvalid is therefore exactly MEM_LATENCY+1 cycles.
  - rdataN holds its last value when rvalidN=0.
- Flush:
  - flush0=1 clears the valid bit of every pipe stage tagged port 0, including an entry that would produce rvalid0 on the next edge.
  - A gnt0 in the same cycle as flush0 is NOT flushed; that new request enters the pipe valid.
  - Port-1 entries are unaffected.
- Throughput: back-to-back grants every cycle, with responses in issue order.

Test Plan:
- Reset: hold rst=1 for 150 ns with clk running → all outputs 0. Release → first gnt follows the first req.
- Single port 0, MEM_LATENCY=1: req0=1, addr0=0 then 32 on consecutive grants.
  - gnt0 each cycle; rvalid0 two cycles after each gnt.
  - rdata0 = memory word at 0, then at 32, in order.
- Contention, STARVE_LIMIT=4: req0=req1=1 continuously.
  - gnt0 for 4 cycles, then gnt1 for 1 cycle, then repeating.
  - rvalid0/rvalid1 follow the same pattern shifted by MEM_LATENCY+1.
- Flush, MEM_LATENCY=2:
  - Issue port-0 reads at 0, 4, 8 on cycles 0, 1, 2, with flush0=1 on cycle 2.
  - Only the read at 8 returns (rvalid0 once, rdata0 = word at 8).
  - An interleaved port-1 read still returns.
- Reset mid-flight: assert rst asynchronously between clock edges while 2 reads are in flight.
  - Outputs clear immediately.
  - No rvalid is produced after rst is released.
- Idle hold: after the last grant, with req0=req1=0 for 10 cycles → mem_read_address is unchanged and no rvalid pulses occur.
